tt_um_hoene_manchester_decoder: RTL

//   Front-end receiver ahead of the protocol selector.
//   - Watches two serial inputs, DIN and BIN, and locks onto whichever starts a frame first.
//   - Recovers Manchester-coded bits and presents each bit with a one-cycle strobe, a 5-bit

---
 rtl/tt_um_hoene_manchester_decoder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/tt_um_hoene_manchester_decoder.sv
// Purpose : two-line Manchester receiver; locks to din or bin and emits bit strobes with word index.
// Latency : a pin edge sampled at cycle k acts at k+3 (k+4 when GLITCH_FILTER_EN is defined).
// Backpressure: none; the output strobe is fire-and-forget, consumer must keep up every bit.
//
// Build option GLITCH_FILTER_EN: adds a 3-sample majority filter behind each synchronizer.

module tt_um_hoene_manchester_decoder #(
    parameter int HALF_BIT    = 8,   // clk cycles per Manchester half-bit
    parameter int IDLE_CYCLES = 64,  // quiet cycles required before a start is accepted
    parameter int CNT_W       = 8    // width of the timing counters
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       bin,
    output logic       out_data,
    output logic       out_clk,
    output logic       out_sync,
    output logic [4:0] bit_counter,
    output logic       in0selected,
    output logic       frame_error
);

    // Acceptance window for a mid-bit edge, measured from the previous mid-bit edge.
    localparam logic [CNT_W-1:0] LO_T   = CNT_W'(3 * HALF_BIT / 2);
    localparam logic [CNT_W-1:0] HI_T   = CNT_W'(5 * HALF_BIT / 2);
    localparam logic [CNT_W-1:0] IDLE_T = CNT_W'(IDLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SYNC  = 2'd2
    } state_t;

    // Bit 0 carries din, bit 1 carries bin through the whole input stage.
    logic [1:0] pin;
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] filt;
    logic [1:0] lvl_q;
    logic [1:0] edge_q;

    assign pin = {bin, din};

    // Two-flop synchronizer for both asynchronous serial lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
        end
    end

`ifdef GLITCH_FILTER_EN
    logic [1:0] hist1_q;
    logic [1:0] hist2_q;

    // Sample history for the majority vote; a one-cycle pulse never wins two of three.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist1_q <= 2'b00;
            hist2_q <= 2'b00;
        end else begin
            hist1_q <= sync_q;
            hist2_q <= hist1_q;
        end
    end

    assign filt = (sync_q & hist1_q) | (sync_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign filt = sync_q;
`endif

    // Registered level and edge detect; lvl_q is the post-edge level whenever edge_q is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q  <= 2'b00;
            edge_q <= 2'b00;
        end else begin
            lvl_q  <= filt;
            edge_q <= filt ^ lvl_q;
        end
    end

    logic [CNT_W-1:0] idle_cnt_q;

    // Quiet-line counter: any high level restarts it, saturates at the idle threshold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (|lvl_q) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != IDLE_T) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic             sel_q, sel_d;       // 1 = din owns the frame
    logic             bnd_q, bnd_d;       // a boundary edge was already seen this bit
    logic             first_q, first_d;   // no data bit reported yet in this frame
    logic             data_q, data_d;
    logic             strobe_q, strobe_d;
    logic             insync_q, insync_d;
    logic [4:0]       bitcnt_q, bitcnt_d;
    logic             ferr_q, ferr_d;

    logic             sel_edge;
    logic             sel_lvl;

    assign sel_edge = sel_q ? edge_q[0] : edge_q[1];
    assign sel_lvl  = sel_q ? lvl_q[0]  : lvl_q[1];

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            sel_q    <= 1'b0;
            bnd_q    <= 1'b0;
            first_q  <= 1'b0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
            insync_q <= 1'b0;
            bitcnt_q <= 5'd0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            sel_q    <= sel_d;
            bnd_q    <= bnd_d;
            first_q  <= first_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            insync_q <= insync_d;
            bitcnt_q <= bitcnt_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state logic: start detection, mid-bit classification and frame termination.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        sel_d    = sel_q;
        bnd_d    = bnd_q;
        first_d  = first_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        insync_d = insync_q;
        bitcnt_d = bitcnt_q;
        ferr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                insync_d = 1'b0;
                if (idle_cnt_q == IDLE_T) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                // The start edge is the mid-bit of a start bit that is never reported.
                if ((edge_q[0] && lvl_q[0]) || (edge_q[1] && lvl_q[1])) begin
                    sel_d    = edge_q[0] && lvl_q[0];
                    insync_d = 1'b1;
                    t_d      = '0;
                    bnd_d    = 1'b0;
                    first_d  = 1'b1;
                    state_d  = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (sel_edge && (t_q < LO_T)) begin
                    if (bnd_q) begin
                        // Two edges inside one early window cannot be Manchester.
                        insync_d = 1'b0;
                        ferr_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        bnd_d = 1'b1;
                        t_d   = t_q + 1'b1;
                    end
                end else if (sel_edge) begin
                    // Frame ends at HI, so any edge reaching here lies inside [LO, HI].
                    data_d   = sel_lvl;
                    strobe_d = 1'b1;
                    t_d      = '0;
                    bnd_d    = 1'b0;
                    first_d  = 1'b0;
                    bitcnt_d = first_q ? 5'd0 : bitcnt_q + 5'd1;
                end else if (t_q == HI_T) begin
                    // Missing mid-bit edge: the frame is over; only whole words are clean.
                    insync_d = 1'b0;
                    ferr_d   = first_q || (bitcnt_q != 5'd31);
                    state_d  = ST_IDLE;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end

            default: begin
                insync_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    assign out_data    = data_q;
    assign out_clk     = strobe_q;
    assign out_sync    = insync_q;
    assign bit_counter = bitcnt_q;
    assign in0selected = sel_q;
    assign frame_error = ferr_q;

endmodule
